rv_plic_target_arb: RTL and testbench

Next-generation per-target interrupt arbiter for the PLIC. It selects the highest-priority pending and enabled source strictly above threshold, with a selectable tie-break policy and an optional extra pipeline stage for large N_SOURCE. It also owns the claim/complete handshake, tracking in-service sources so that a claimed ID is never presented again before it completes. There is one instance per hart context, sitting between the gateway/IP array and the claim/complete register interface.

---
 rtl/rv_plic_pkg.sv | 39 +++
 rtl/rv_plic_max_tree.sv | 28 ++
 rtl/rv_plic_target_arb.sv | 137 +++++++++++++
 tb/tb_rv_plic_target_arb.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_plic_pkg.sv
// Shared types for the per-target PLIC arbiter: tie-break policy and the
// max-tree node together with its compare rule.
package rv_plic_pkg;

  typedef enum logic {
    TB_LOWEST_ID,
    TB_ROUND_ROBIN
  } tie_break_e;

  // Node fields are sized for the largest supported configuration
  // (MAX_PRIO <= 255, N_SOURCE <= 1023); narrower instances zero-extend.
  localparam int NODE_PRIOW = 8;
  localparam int NODE_SRCW  = 10;

  typedef struct packed {
    logic                  valid;
    logic [NODE_PRIOW-1:0] prio;
    logic [NODE_SRCW-1:0]  idx;
  } arb_node_t;

  // lo must hold lower indices than hi, so equal keys keep lo.  In round-robin
  // mode an extra LSB favours indices at or above the pointer.
  function automatic arb_node_t node_pick(input arb_node_t            lo,
                                          input arb_node_t            hi,
                                          input tie_break_e           tb,
                                          input logic [NODE_SRCW-1:0] rr_ptr);
    logic [NODE_PRIOW:0] key_lo;
    logic [NODE_PRIOW:0] key_hi;
    arb_node_t           win;
    key_lo = {lo.prio, (tb == TB_ROUND_ROBIN) && (lo.idx >= rr_ptr)};
    key_hi = {hi.prio, (tb == TB_ROUND_ROBIN) && (hi.idx >= rr_ptr)};
    if (!hi.valid)            win = lo;
    else if (!lo.valid)       win = hi;
    else if (key_hi > key_lo) win = hi;
    else                      win = lo;
    return win;
  endfunction

endpackage

// File: rtl/rv_plic_max_tree.sv
// Combinational binary max-tree over arbiter nodes.  Leaves sit in index
// order, so the left subtree of every node holds the lower indices.
module rv_plic_max_tree
  import rv_plic_pkg::*;
#(
  parameter int         N_LEAF    = 32,
  parameter tie_break_e TIE_BREAK = TB_LOWEST_ID
) (
  input  arb_node_t [N_LEAF-1:0] i_leaf,
  input  logic [NODE_SRCW-1:0]   i_rr_ptr,
  output arb_node_t              o_win
);

  localparam int N_PAD = (N_LEAF <= 1) ? 1 : (1 << $clog2(N_LEAF));

  // Heap layout: node k has children 2k+1 / 2k+2, padding leaves are invalid.
  arb_node_t w_node [2*N_PAD-1];

  always_comb begin
    for (int k = 0; k < 2*N_PAD-1; k++) w_node[k] = '0;
    for (int i = 0; i < N_LEAF; i++) w_node[N_PAD-1+i] = i_leaf[i];
    for (int k = N_PAD-2; k >= 0; k--)
      w_node[k] = node_pick(w_node[2*k+1], w_node[2*k+2], TIE_BREAK, i_rr_ptr);
  end

  assign o_win = w_node[0];

endmodule

// File: rtl/rv_plic_target_arb.sv
// Per-target PLIC arbiter: presents the highest-priority eligible source above
// threshold and tracks claimed-but-not-completed sources.
module rv_plic_target_arb
  import rv_plic_pkg::*;
#(
  parameter int    N_SOURCE  = 32,
  parameter int    MAX_PRIO  = 7,
  parameter string TIE_BREAK = "LOWEST_ID",
  parameter int    LATENCY   = 1,
  localparam int   SRCW      = $clog2(N_SOURCE+1),
  localparam int   PRIOW     = $clog2(MAX_PRIO+1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_SOURCE-1:0]            ip,
  input  logic [N_SOURCE-1:0]            ie,
  input  logic [N_SOURCE-1:0][PRIOW-1:0] prio,
  input  logic [PRIOW-1:0]               threshold,
  input  logic                           claim_i,
  input  logic                           complete_i,
  input  logic [SRCW-1:0]                complete_id_i,
  output logic                           irq_o,
  output logic [SRCW-1:0]                irq_id_o,
  output logic                           claim_valid_o,
  output logic [SRCW-1:0]                claim_id_o,
  output logic [N_SOURCE-1:0]            in_service_o
);

  localparam tie_break_e TB = (TIE_BREAK == "ROUND_ROBIN") ? TB_ROUND_ROBIN : TB_LOWEST_ID;

  arb_node_t [N_SOURCE-1:0] w_leaf;
  arb_node_t                w_win;
  logic [NODE_SRCW-1:0]     w_rr_ptr;
  logic [SRCW-1:0]          w_irq_id_next;
  logic                     w_claim_hit;
  logic                     w_suppress;
  logic [N_SOURCE-1:0]      w_set;
  logic [N_SOURCE-1:0]      w_clr;

  logic [N_SOURCE-1:0]      r_in_service;
  logic [SRCW-1:0]          r_rr_ptr;
  logic                     r_sup_cnt;
  logic [SRCW-1:0]          r_irq_id;
  logic                     r_claim_valid;
  logic [SRCW-1:0]          r_claim_id;

  always_comb begin
    w_leaf = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      w_leaf[i].valid = ip[i] & ie[i] & ~r_in_service[i] & (prio[i] > threshold);
      w_leaf[i].prio  = NODE_PRIOW'(prio[i]);
      w_leaf[i].idx   = NODE_SRCW'(i);
    end
  end

  assign w_rr_ptr = NODE_SRCW'(r_rr_ptr);

  if (LATENCY == 2) begin : g_lat2
    localparam int N_LO = N_SOURCE / 2;
    arb_node_t w_lo;
    arb_node_t w_hi;
    arb_node_t r_lo;
    arb_node_t r_hi;

    rv_plic_max_tree #(.N_LEAF(N_LO), .TIE_BREAK(TB)) u_tree_lo (
      .i_leaf   (w_leaf[N_LO-1:0]),
      .i_rr_ptr (w_rr_ptr),
      .o_win    (w_lo)
    );

    rv_plic_max_tree #(.N_LEAF(N_SOURCE-N_LO), .TIE_BREAK(TB)) u_tree_hi (
      .i_leaf   (w_leaf[N_SOURCE-1:N_LO]),
      .i_rr_ptr (w_rr_ptr),
      .o_win    (w_hi)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_lo <= '0;
        r_hi <= '0;
      end else begin
        r_lo <= w_lo;
        r_hi <= w_hi;
      end
    end

    assign w_win = node_pick(r_lo, r_hi, TB, w_rr_ptr);
  end else begin : g_lat1
    rv_plic_max_tree #(.N_LEAF(N_SOURCE), .TIE_BREAK(TB)) u_tree (
      .i_leaf   (w_leaf),
      .i_rr_ptr (w_rr_ptr),
      .o_win    (w_win)
    );
  end

  // Re-checking the threshold keeps a two-stage winner honest if it moved.
  assign w_claim_hit   = claim_i & (r_irq_id != '0);
  assign w_suppress    = w_claim_hit | r_sup_cnt;
  assign w_irq_id_next = (w_suppress || !w_win.valid || (w_win.prio <= NODE_PRIOW'(threshold)))
                         ? '0 : SRCW'(w_win.idx + NODE_SRCW'(1));

  // IDs 0 and above N_SOURCE never match a slot, so they fall through silently.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      w_set[i] = w_claim_hit & (r_irq_id == SRCW'(i + 1));
      w_clr[i] = complete_i & (complete_id_i == SRCW'(i + 1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_in_service  <= '0;
      r_rr_ptr      <= '0;
      r_sup_cnt     <= 1'b0;
      r_irq_id      <= '0;
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else begin
      r_in_service  <= (r_in_service & ~w_clr) | w_set;
      r_irq_id      <= w_irq_id_next;
      r_claim_valid <= claim_i;
      r_claim_id    <= claim_i ? r_irq_id : '0;
      r_sup_cnt     <= w_claim_hit && (LATENCY == 2);
      if (w_claim_hit && (TB == TB_ROUND_ROBIN))
        r_rr_ptr <= (r_irq_id == SRCW'(N_SOURCE)) ? '0 : r_irq_id;
    end
  end

  assign irq_o         = (r_irq_id != '0);
  assign irq_id_o      = r_irq_id;
  assign claim_valid_o = r_claim_valid;
  assign claim_id_o    = r_claim_id;
  assign in_service_o  = r_in_service;

endmodule

// File: tb/tb_rv_plic_target_arb.sv
// Bench for rv_plic_target_arb: a LOWEST_ID/LATENCY=1 instance and a
// ROUND_ROBIN/LATENCY=2 instance driven side by side; claims go through a scoreboard.
module tb_rv_plic_target_arb;

  localparam int N  = 32;
  localparam int SW = 6;
  localparam int PW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          ip;
  logic [N-1:0]          ie;
  logic [N-1:0][PW-1:0]  prio;
  logic [PW-1:0]         threshold;
  logic                  claim       [2];
  logic                  complete    [2];
  logic [SW-1:0]         complete_id [2];
  logic                  irq         [2];
  logic [SW-1:0]         irq_id      [2];
  logic                  claim_valid [2];
  logic [SW-1:0]         claim_id    [2];
  logic [N-1:0]          in_service  [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] q_exp0 [$];
  logic [SW-1:0] q_exp1 [$];
  logic [SW-1:0] mon_exp;
  logic          mon_ok;

  always #5 clk = ~clk;

  rv_plic_target_arb #(.N_SOURCE(N), .MAX_PRIO(7), .TIE_BREAK("LOWEST_ID"), .LATENCY(1)) u_dut_lid (
    .clk_i(clk), .rst_i(rst), .ip(ip), .ie(ie), .prio(prio), .threshold(threshold),
    .claim_i(claim[0]), .complete_i(complete[0]), .complete_id_i(complete_id[0]),
    .irq_o(irq[0]), .irq_id_o(irq_id[0]), .claim_valid_o(claim_valid[0]),
    .claim_id_o(claim_id[0]), .in_service_o(in_service[0])
  );

  rv_plic_target_arb #(.N_SOURCE(N), .MAX_PRIO(7), .TIE_BREAK("ROUND_ROBIN"), .LATENCY(2)) u_dut_rr (
    .clk_i(clk), .rst_i(rst), .ip(ip), .ie(ie), .prio(prio), .threshold(threshold),
    .claim_i(claim[1]), .complete_i(complete[1]), .complete_id_i(complete_id[1]),
    .irq_o(irq[1]), .irq_id_o(irq_id[1]), .claim_valid_o(claim_valid[1]),
    .claim_id_o(claim_id[1]), .in_service_o(in_service[1])
  );

  // Scoreboard consumer: every claim_valid_o pulse pops one expected ID.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (claim_valid[d] === 1'b1) begin
        mon_ok = 1'b0;
        if (d == 0 && q_exp0.size() > 0) begin
          mon_exp = q_exp0.pop_front();
          mon_ok  = 1'b1;
        end else if (d == 1 && q_exp1.size() > 0) begin
          mon_exp = q_exp1.pop_front();
          mon_ok  = 1'b1;
        end
        n_checks++;
        if (!mon_ok) begin
          n_fail++;
          $display("FAIL claim_pulse dut%0d: unexpected claim_valid_o with claim_id_o=%0d, none required", d, claim_id[d]);
        end else if (claim_id[d] !== mon_exp) begin
          n_fail++;
          $display("FAIL claim_id dut%0d: got %0d required %0d", d, claim_id[d], mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_claim(input logic v);
    claim[0] = v;
    claim[1] = v;
  endtask

  task automatic set_complete(input logic v, input logic [SW-1:0] id);
    complete[0]    = v;
    complete[1]    = v;
    complete_id[0] = id;
    complete_id[1] = id;
  endtask

  task automatic push_exp(input logic [SW-1:0] e0, input logic [SW-1:0] e1);
    q_exp0.push_back(e0);
    q_exp1.push_back(e1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ip = '1;
    ie = '1;
    threshold = '0;
    for (int i = 0; i < N; i++) prio[i] = 3'd1;
    prio[3] = 3'd5;
    set_claim(1'b0);
    set_complete(1'b0, '0);
    nx(3);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq[d] !== 1'b0 || irq_id[d] !== '0 || claim_valid[d] !== 1'b0 || claim_id[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: irq=%b id=%0d cv=%b cid=%0d required all 0",
                 d, irq[d], irq_id[d], claim_valid[d], claim_id[d]);
      end
      n_checks++;
      if (in_service[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_in_service dut%0d: got %h required 0", d, in_service[d]);
      end
    end
    rst = 1'b0;
    nx(1);
    n_checks++;
    if (irq[0] !== 1'b1 || irq_id[0] !== 6'd4) begin
      n_fail++;
      $display("FAIL latency1_first dut0: irq=%b id=%0d required 1/4", irq[0], irq_id[0]);
    end
    n_checks++;
    if (irq_id[1] !== 6'd0) begin
      n_fail++;
      $display("FAIL latency2_early dut1: id=%0d required 0", irq_id[1]);
    end
    nx(1);
    n_checks++;
    if (irq[1] !== 1'b1 || irq_id[1] !== 6'd4) begin
      n_fail++;
      $display("FAIL latency2_first dut1: irq=%b id=%0d required 1/4", irq[1], irq_id[1]);
    end
  endtask

  task automatic test_threshold();
    threshold = 3'd5;
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq[d] !== 1'b0 || irq_id[d] !== '0) begin
        n_fail++;
        $display("FAIL thr_equal dut%0d: irq=%b id=%0d required 0/0", d, irq[d], irq_id[d]);
      end
    end
    threshold = 3'd4;
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq_id[d] !== 6'd4) begin
        n_fail++;
        $display("FAIL thr_below dut%0d: id=%0d required 4", d, irq_id[d]);
      end
    end
    prio[3] = 3'd7;
    threshold = 3'd7;
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL thr_max dut%0d: irq=%b required 0", d, irq[d]);
      end
    end
    prio[3] = 3'd5;
    prio[5] = 3'd3;
    threshold = 3'd0;
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq_id[d] !== 6'd4) begin
        n_fail++;
        $display("FAIL thr_restore dut%0d: id=%0d required 4", d, irq_id[d]);
      end
    end
  endtask

  task automatic test_claim_complete();
    set_claim(1'b1);
    push_exp(6'd4, 6'd4);
    nx(1);
    claim[0] = 1'b0;
    q_exp1.push_back(6'd0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== 32'h0000_0008 || irq[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL claim_set dut%0d: in_service=%h irq=%b required 00000008/0", d, in_service[d], irq[d]);
      end
    end
    nx(1);
    claim[1] = 1'b0;
    n_checks++;
    if (irq_id[0] !== 6'd6) begin
      n_fail++;
      $display("FAIL claim_next dut0: id=%0d required 6", irq_id[0]);
    end
    n_checks++;
    if (irq[1] !== 1'b0 || in_service[1] !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL claim_suppress dut1: irq=%b in_service=%h required 0/00000008", irq[1], in_service[1]);
    end
    nx(1);
    n_checks++;
    if (irq_id[1] !== 6'd6) begin
      n_fail++;
      $display("FAIL claim_next dut1: id=%0d required 6", irq_id[1]);
    end
    set_complete(1'b1, 6'd4);
    nx(1);
    set_complete(1'b0, '0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== '0) begin
        n_fail++;
        $display("FAIL complete_clear dut%0d: in_service=%h required 0", d, in_service[d]);
      end
    end
    nx(1);
    n_checks++;
    if (irq_id[0] !== 6'd4 || irq_id[1] !== 6'd6) begin
      n_fail++;
      $display("FAIL complete_latency: dut0 id=%0d dut1 id=%0d required 4/6", irq_id[0], irq_id[1]);
    end
    nx(1);
    n_checks++;
    if (irq_id[1] !== 6'd4) begin
      n_fail++;
      $display("FAIL complete_reappear dut1: id=%0d required 4", irq_id[1]);
    end
  endtask

  task automatic test_complete_rules();
    logic [SW-1:0] bad_ids [3];
    bad_ids = '{6'd0, 6'd33, 6'd9};
    ip = '0;
    ip[4] = 1'b1;
    ip[6] = 1'b1;
    prio[4] = 3'd5;
    prio[6] = 3'd6;
    nx(3);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq_id[d] !== 6'd7) begin
        n_fail++;
        $display("FAIL rules_start dut%0d: id=%0d required 7", d, irq_id[d]);
      end
    end
    set_claim(1'b1);
    push_exp(6'd7, 6'd7);
    nx(1);
    set_claim(1'b0);
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq_id[d] !== 6'd5 || in_service[d] !== 32'h0000_0040) begin
        n_fail++;
        $display("FAIL rules_claim7 dut%0d: id=%0d in_service=%h required 5/00000040", d, irq_id[d], in_service[d]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      set_complete(1'b1, bad_ids[k]);
      nx(1);
      set_complete(1'b0, '0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (in_service[d] !== 32'h0000_0040) begin
          n_fail++;
          $display("FAIL complete_ignored id%0d dut%0d: in_service=%h required 00000040", bad_ids[k], d, in_service[d]);
        end
      end
    end
    set_claim(1'b1);
    push_exp(6'd5, 6'd5);
    set_complete(1'b1, 6'd7);
    nx(1);
    set_claim(1'b0);
    set_complete(1'b0, '0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== 32'h0000_0010) begin
        n_fail++;
        $display("FAIL claim_and_complete dut%0d: in_service=%h required 00000010", d, in_service[d]);
      end
    end
    nx(2);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq_id[d] !== 6'd7) begin
        n_fail++;
        $display("FAIL rules_reappear7 dut%0d: id=%0d required 7", d, irq_id[d]);
      end
    end
    set_claim(1'b1);
    push_exp(6'd7, 6'd7);
    set_complete(1'b1, 6'd7);
    nx(1);
    set_claim(1'b0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== 32'h0000_0050) begin
        n_fail++;
        $display("FAIL same_id_set_wins dut%0d: in_service=%h required 00000050", d, in_service[d]);
      end
    end
    set_complete(1'b1, 6'd5);
    nx(1);
    set_complete(1'b1, 6'd7);
    nx(1);
    set_complete(1'b0, '0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== '0) begin
        n_fail++;
        $display("FAIL rules_cleanup dut%0d: in_service=%h required 0", d, in_service[d]);
      end
    end
  endtask

  task automatic test_claim_idle();
    ip = '0;
    nx(3);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (irq[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_irq dut%0d: irq=%b required 0", d, irq[d]);
      end
    end
    set_claim(1'b1);
    push_exp(6'd0, 6'd0);
    nx(1);
    set_claim(1'b0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== '0) begin
        n_fail++;
        $display("FAIL idle_claim_state dut%0d: in_service=%h required 0", d, in_service[d]);
      end
    end
    nx(1);
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] exp_rr [4];
    exp_rr = '{6'd2, 6'd5, 6'd9, 6'd2};
    rst = 1'b1;
    ip = '0;
    ip[1] = 1'b1;
    ip[4] = 1'b1;
    ip[8] = 1'b1;
    for (int i = 0; i < N; i++) prio[i] = 3'd3;
    threshold = '0;
    nx(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nx(3);
      n_checks++;
      if (irq_id[0] !== 6'd2) begin
        n_fail++;
        $display("FAIL lowest_id_tie round%0d: id=%0d required 2", k, irq_id[0]);
      end
      n_checks++;
      if (irq_id[1] !== exp_rr[k]) begin
        n_fail++;
        $display("FAIL round_robin_tie round%0d: id=%0d required %0d", k, irq_id[1], exp_rr[k]);
      end
      set_claim(1'b1);
      push_exp(6'd2, exp_rr[k]);
      nx(1);
      set_claim(1'b0);
      nx(3);
      if (k < 3) begin
        complete[0]    = 1'b1;
        complete_id[0] = 6'd2;
        complete[1]    = 1'b1;
        complete_id[1] = exp_rr[k];
        nx(1);
        set_complete(1'b0, '0);
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== 32'h0000_0002) begin
        n_fail++;
        $display("FAIL rr_final_state dut%0d: in_service=%h required 00000002", d, in_service[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    nx(1);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_service[d] !== '0 || irq[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: in_service=%h irq=%b required 0/0", d, in_service[d], irq[d]);
      end
    end
    nx(2);
    rst = 1'b0;
    nx(1);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_threshold();
    test_claim_complete();
    test_complete_rules();
    test_claim_idle();
    test_round_robin();
    test_async_reset();
    nx(2);
    n_checks++;
    if (q_exp0.size() != 0 || q_exp1.size() != 0) begin
      n_fail++;
      $display("FAIL claim_queue_drain: outstanding dut0=%0d dut1=%0d required 0/0", q_exp0.size(), q_exp1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
